// File: rtl/macc_loader.sv
// Framed word-stream loader feeding the macc A/B/C matrix buffers.
// Optional trailing XOR checksum per frame: define MACC_LOADER_CKSUM_EN.
module macc_loader #(
    parameter int unsigned MAX_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [2:0]  wen,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    input  logic        err_clr
);

    typedef enum logic [1:0] {StIdle, StLoad, StCksum, StDone} state_e;

    localparam logic [15:0] LP_MAX_WORDS = 16'(MAX_WORDS);

    state_e      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [15:0] r_wcnt, w_wcnt_nxt;
    logic [1:0]  r_tgt, w_tgt_nxt;
    logic [2:0]  r_wen, w_wen_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic [1:0]  r_err, w_err_nxt;
    logic [2:0]  w_tgt_onehot;
    logic        w_xfer;
`ifdef MACC_LOADER_CKSUM_EN
    logic [31:0] r_xor, w_xor_nxt;
`endif

    // in_ready is gated by rst_n so it reads 0 for the whole reset interval
    assign in_ready = rst_n & (r_state != StDone);
    assign w_xfer   = in_valid & in_ready;
    assign wen      = r_wen;
    assign wdata    = r_wdata;
    assign busy     = (r_state != StIdle);
    assign done     = (r_state == StDone);
    assign err      = r_err;

    always_comb begin
        w_tgt_onehot = 3'b000;
        case (r_tgt)
            2'b00:   w_tgt_onehot = 3'b100;
            2'b01:   w_tgt_onehot = 3'b010;
            2'b10:   w_tgt_onehot = 3'b001;
            default: w_tgt_onehot = 3'b000;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wcnt_nxt  = r_wcnt;
        w_tgt_nxt   = r_tgt;
        w_wen_nxt   = 3'b000;
        w_wdata_nxt = r_wdata;
        // Clear first so a same-cycle set event below wins
        w_err_nxt   = err_clr ? 2'b00 : r_err;
`ifdef MACC_LOADER_CKSUM_EN
        w_xor_nxt   = r_xor;
`endif
        case (r_state)
            StIdle: begin
                if (w_xfer) begin
                    w_tgt_nxt  = in_data[31:30];
                    w_cnt_nxt  = in_data[15:0];
                    w_wcnt_nxt = 16'd0;
`ifdef MACC_LOADER_CKSUM_EN
                    w_xor_nxt  = 32'd0;
`endif
                    if (in_data[31:30] == 2'b11) begin
                        w_err_nxt[0] = 1'b1;
                    end
                    w_state_nxt = (in_data[15:0] == 16'd0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                if (w_xfer) begin
                    w_cnt_nxt = r_cnt - 16'd1;
`ifdef MACC_LOADER_CKSUM_EN
                    w_xor_nxt = r_xor ^ in_data;
`endif
                    if (r_wcnt < LP_MAX_WORDS) begin
                        if (w_tgt_onehot != 3'b000) begin
                            w_wen_nxt   = w_tgt_onehot;
                            w_wdata_nxt = in_data;
                            w_wcnt_nxt  = r_wcnt + 16'd1;
                        end
                    end else begin
                        w_err_nxt[0] = 1'b1;
                    end
                    if (r_cnt == 16'd1) begin
`ifdef MACC_LOADER_CKSUM_EN
                        w_state_nxt = StCksum;
`else
                        w_state_nxt = StDone;
`endif
                    end
                end
            end
            StCksum: begin
`ifdef MACC_LOADER_CKSUM_EN
                if (w_xfer) begin
                    if (in_data != r_xor) begin
                        w_err_nxt[1] = 1'b1;
                    end
                    w_state_nxt = StDone;
                end
`else
                w_state_nxt = StIdle;
`endif
            end
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= 16'd0;
            r_wcnt  <= 16'd0;
            r_tgt   <= 2'b00;
            r_wen   <= 3'b000;
            r_wdata <= 32'd0;
            r_err   <= 2'b00;
`ifdef MACC_LOADER_CKSUM_EN
            r_xor   <= 32'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_tgt   <= w_tgt_nxt;
            r_wen   <= w_wen_nxt;
            r_wdata <= w_wdata_nxt;
            r_err   <= w_err_nxt;
`ifdef MACC_LOADER_CKSUM_EN
            r_xor   <= w_xor_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_macc_loader.sv
// Directed self-checking bench for macc_loader (default MAX_WORDS=16).
module tb_macc_loader;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  wen;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic        err_clr;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [2:0]  log_en[$];
    logic [31:0] log_dat[$];
    int          log_cyc[$];
    int          done_cnt;
    int          done_cyc;
    logic [31:0] payload[$];

    macc_loader #(.MAX_WORDS(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wen      (wen),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_clr  (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write and done pulse mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (wen != 3'b000) begin
                log_en.push_back(wen);
                log_dat.push_back(wdata);
                log_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        log_en.delete();
        log_dat.delete();
        log_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    // Present one word and hold it until accepted; called 1 time unit after a rising edge
    task automatic xfer(input logic [31:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 20) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic gap_busy(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("gap_busy", {31'd0, busy}, 32'd1);
            chk("gap_wen", {29'd0, wen}, 32'd0);
        end
    endtask

    // Header, payload from the queue, then the checksum when that build option is on
    task automatic send_frame(input logic [31:0] hdr);
        logic [31:0] x;
        x = 32'd0;
        xfer(hdr);
        foreach (payload[i]) begin
            xfer(payload[i]);
            x = x ^ payload[i];
        end
`ifdef MACC_LOADER_CKSUM_EN
        if (payload.size() != 0) xfer(x);
`endif
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    initial begin
        int bad_en;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'd0;
        err_clr  = 1'b0;
        clear_logs();

        // Reset state
        #2;
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_wen", {29'd0, wen}, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {30'd0, err}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_ready", {31'd0, in_ready}, 32'd1);

        // Matrix A, three words back to back
        clear_logs();
        payload = '{32'hdeadbeef, 32'ha5a5a5a5, 32'hfeed2b0b};
        send_frame(32'h0000_0003);
        idle(4);
        chk("a_nwr", log_en.size(), 32'd3);
        if (log_en.size() == 3) begin
            chk("a_en0", {29'd0, log_en[0]}, 32'd4);
            chk("a_en2", {29'd0, log_en[2]}, 32'd4);
            chk("a_d0", log_dat[0], 32'hdeadbeef);
            chk("a_d1", log_dat[1], 32'ha5a5a5a5);
            chk("a_d2", log_dat[2], 32'hfeed2b0b);
            chk("a_consec", log_cyc[2] - log_cyc[0], 32'd2);
`ifndef MACC_LOADER_CKSUM_EN
            chk("a_done_cyc", done_cyc, log_cyc[2]);
`endif
        end
        chk("a_done_cnt", done_cnt, 32'd1);
        chk("a_err", {30'd0, err}, 32'd0);

        // Matrix B with gaps between words
        clear_logs();
        xfer(32'h4000_0002);
        gap_busy(2);
        xfer(32'd1);
        gap_busy(2);
        xfer(32'd2);
`ifdef MACC_LOADER_CKSUM_EN
        xfer(32'd3);
`endif
        idle(4);
        chk("b_nwr", log_en.size(), 32'd2);
        if (log_en.size() == 2) begin
            chk("b_en0", {29'd0, log_en[0]}, 32'd2);
            chk("b_en1", {29'd0, log_en[1]}, 32'd2);
            chk("b_d0", log_dat[0], 32'd1);
            chk("b_d1", log_dat[1], 32'd2);
            chk("b_gap", log_cyc[1] - log_cyc[0], 32'd3);
        end
        chk("b_done_cnt", done_cnt, 32'd1);
        chk("b_err", {30'd0, err}, 32'd0);

        // Illegal target: payload swallowed, no writes, err[0]
        clear_logs();
        payload = '{32'h1234_5678, 32'h9abc_def0};
        send_frame(32'hC000_0002);
        idle(4);
        chk("ill_nwr", log_en.size(), 32'd0);
        chk("ill_err", {30'd0, err}, 32'd1);
        chk("ill_done_cnt", done_cnt, 32'd1);
        pulse_clr();
        chk("ill_clr", {30'd0, err}, 32'd0);

        // Matrix C overflow: 18 words, 16 written
        clear_logs();
        payload.delete();
        for (int i = 1; i <= 18; i++) payload.push_back(32'(i));
        send_frame(32'h8000_0012);
        idle(4);
        chk("ovf_nwr", log_en.size(), 32'd16);
        if (log_en.size() == 16) begin
            bad_en = 0;
            foreach (log_en[i]) if (log_en[i] != 3'b001) bad_en++;
            chk("ovf_en", bad_en, 32'd0);
            chk("ovf_first", log_dat[0], 32'd1);
            chk("ovf_last", log_dat[15], 32'd16);
        end
        chk("ovf_err", {30'd0, err}, 32'd1);
        chk("ovf_done_cnt", done_cnt, 32'd1);
        pulse_clr();
        chk("ovf_clr", {30'd0, err}, 32'd0);

        // Zero-length frame
        clear_logs();
        xfer(32'h0000_0000);
        idle(3);
        chk("zero_nwr", log_en.size(), 32'd0);
        chk("zero_done_cnt", done_cnt, 32'd1);

`ifdef MACC_LOADER_CKSUM_EN
        clear_logs();
        xfer(32'h0000_0002);
        xfer(32'h0000_000F);
        xfer(32'h0000_00F0);
        xfer(32'h0000_00FF);
        idle(4);
        chk("ck_ok_err", {30'd0, err}, 32'd0);
        xfer(32'h0000_0002);
        xfer(32'h0000_000F);
        xfer(32'h0000_00F0);
        xfer(32'h0000_0000);
        idle(4);
        chk("ck_bad_err", {30'd0, err}, 32'd2);
        chk("ck_done_cnt", done_cnt, 32'd2);
        pulse_clr();
`endif

        // Reset in mid-frame, then a clean frame
        xfer(32'h0000_0004);
        xfer(32'h0000_0011);
        xfer(32'h0000_0022);
        chk("pre_rst_wen", {29'd0, wen}, 32'd4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wen", {29'd0, wen}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_logs();
        payload = '{32'h0000_0001};
        send_frame(32'h0000_0001);
        idle(4);
        chk("post_rst_nwr", log_en.size(), 32'd1);
        if (log_en.size() == 1) begin
            chk("post_rst_en", {29'd0, log_en[0]}, 32'd4);
            chk("post_rst_d", log_dat[0], 32'd1);
        end
        chk("post_rst_done", done_cnt, 32'd1);
        chk("post_rst_err", {30'd0, err}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
